// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the stream FIFO family.
package fifo_pkg;

   // Width of the saturating drop counter.
   localparam int DROP_W = 16;

   // Width needed to hold an occupancy of 0 .. depth+1 (array plus output register).
   function automatic int fifo_cw(input int depth);
      return $clog2(depth + 2);
   endfunction

   // Address width of a depth-entry array; never less than one bit.
   function automatic int fifo_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_sdp_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Contents are not reset; occupancy tracking in the parent decides what is meaningful.
module fifo_sdp_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16,
   localparam int AW   = fifo_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port: store one word on an accepted push.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   // Read port: head entry is visible without a clock so the FIFO can fall through.
   always_comb begin
      rd_data = mem_q[rd_addr];
   end

endmodule

// File: rtl/fifo_stream_ctrl.sv
// First-word-fall-through stream FIFO with valid/ready handshakes, optional output
// register, synchronous flush, almost-full/empty flags and telemetry counters.
module fifo_stream_ctrl
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int OUT_REG   = 0,
   localparam int CW       = fifo_cw(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              input_valid,
   output logic              input_ready,
   input  logic [WIDTH-1:0]  input_data,
   output logic              output_valid,
   input  logic              output_ready,
   output logic [WIDTH-1:0]  output_data,
   output logic [CW-1:0]     count,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CW-1:0]     watermark,
   output logic [DROP_W-1:0] drop_count
);

   localparam int AW = fifo_aw(DEPTH);
   // Total capacity: the array plus the output register when present.
   localparam logic [CW-1:0] CAP  = CW'(DEPTH + OUT_REG);
   // Thresholds are expected to lie within 0 .. DEPTH+1.
   localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   // Pointers wrap by comparison so any depth works, not just powers of two.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     arr_cnt_q, arr_cnt_d, wm_q, wm_d, count_d;
   logic              reg_vld_q, reg_vld_d;
   logic [WIDTH-1:0]  reg_data_q, reg_data_d, rd_data;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              push, pop, arr_rd, arr_nonempty;

   fifo_sdp_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data (input_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   // Handshake, head selection and status outputs, all derived from current state.
   always_comb begin
      count        = arr_cnt_q + CW'(reg_vld_q);
      arr_nonempty = (arr_cnt_q != '0);
      input_ready  = !flush && (count < CAP);
      if (OUT_REG != 0) begin
         output_valid = reg_vld_q && !flush;
         output_data  = reg_data_q;
      end else begin
         output_valid = arr_nonempty && !flush;
         output_data  = rd_data;
      end
      push = input_valid && input_ready;
      pop  = output_valid && output_ready;
      // With the output register, the array feeds it whenever it is empty or being drained.
      if (OUT_REG != 0) arr_rd = (!reg_vld_q || pop) && arr_nonempty && !flush;
      else              arr_rd = pop;
      almost_full  = (count >= AF_C);
      almost_empty = (count <= AE_C);
      watermark    = wm_q;
      drop_count   = drop_q;
   end

   // Next-state logic for pointers, occupancy, output register and counters.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      arr_cnt_d  = arr_cnt_q;
      reg_vld_d  = reg_vld_q;
      reg_data_d = reg_data_q;
      drop_d     = drop_q;
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         arr_cnt_d = '0;
         reg_vld_d = 1'b0;
      end else begin
         if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
         if (arr_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
         arr_cnt_d = arr_cnt_q + CW'(push) - CW'(arr_rd);
         if (OUT_REG != 0) begin
            if (arr_rd) begin
               reg_vld_d  = 1'b1;
               reg_data_d = rd_data;
            end else if (pop) begin
               reg_vld_d  = 1'b0;
            end
         end
         if (input_valid && !input_ready && (drop_q != '1)) drop_d = drop_q + 1'b1;
      end
      count_d = arr_cnt_d + CW'(reg_vld_d);
      if (flush)              wm_d = '0;
      else if (count_d > wm_q) wm_d = count_d;
      else                    wm_d = wm_q;
   end

   // Control state: cleared asynchronously so a reset empties the FIFO at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         arr_cnt_q <= '0;
         reg_vld_q <= 1'b0;
         wm_q      <= '0;
         drop_q    <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         arr_cnt_q <= arr_cnt_d;
         reg_vld_q <= reg_vld_d;
         wm_q      <= wm_d;
         drop_q    <= drop_d;
      end
   end

   // Output data register: qualified by reg_vld_q, so it needs no reset.
   always_ff @(posedge clk) begin
      reg_data_q <= reg_data_d;
   end

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Directed bench for fifo_stream_ctrl: depth-16 fall-through, depth-5 wrap stream,
// and depth-16 registered-output variants, each with hand-derived expectations.
module tb_fifo_stream_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // A: DEPTH=16, OUT_REG=0, WIDTH=4
   logic       a_flush = 0, a_iv = 0, a_ir, a_ov, a_ordy = 0, a_af, a_ae;
   logic [3:0] a_din = '0, a_dout;
   logic [4:0] a_cnt, a_wm;
   logic [15:0] a_drop;
   // B: DEPTH=5, OUT_REG=0, WIDTH=8
   logic       b_flush = 0, b_iv = 0, b_ir, b_ov, b_ordy = 0, b_af, b_ae;
   logic [7:0] b_din = '0, b_dout;
   logic [2:0] b_cnt, b_wm;
   logic [15:0] b_drop;
   // C: DEPTH=16, OUT_REG=1, WIDTH=4
   logic       c_flush = 0, c_iv = 0, c_ir, c_ov, c_ordy = 0, c_af, c_ae;
   logic [3:0] c_din = '0, c_dout;
   logic [4:0] c_cnt, c_wm;
   logic [15:0] c_drop;

   fifo_stream_ctrl #(.WIDTH(4), .DEPTH(16), .OUT_REG(0)) u_a (
      .clk(clk), .reset(reset), .flush(a_flush), .input_valid(a_iv), .input_ready(a_ir),
      .input_data(a_din), .output_valid(a_ov), .output_ready(a_ordy), .output_data(a_dout),
      .count(a_cnt), .almost_full(a_af), .almost_empty(a_ae), .watermark(a_wm), .drop_count(a_drop));

   fifo_stream_ctrl #(.WIDTH(8), .DEPTH(5), .OUT_REG(0)) u_b (
      .clk(clk), .reset(reset), .flush(b_flush), .input_valid(b_iv), .input_ready(b_ir),
      .input_data(b_din), .output_valid(b_ov), .output_ready(b_ordy), .output_data(b_dout),
      .count(b_cnt), .almost_full(b_af), .almost_empty(b_ae), .watermark(b_wm), .drop_count(b_drop));

   fifo_stream_ctrl #(.WIDTH(4), .DEPTH(16), .OUT_REG(1)) u_c (
      .clk(clk), .reset(reset), .flush(c_flush), .input_valid(c_iv), .input_ready(c_ir),
      .input_data(c_din), .output_valid(c_ov), .output_ready(c_ordy), .output_data(c_dout),
      .count(c_cnt), .almost_full(c_af), .almost_empty(c_ae), .watermark(c_wm), .drop_count(c_drop));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q[$];
   logic [7:0] exp_b;
   logic [31:0] vpat = 32'hB5A7_6D3F;
   logic [31:0] rpat = 32'h6DB5_9AE7;
   int sent, recvd;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_ir",   32'(a_ir),   32'd1);
      check("rst_ov",   32'(a_ov),   32'd0);
      check("rst_ae",   32'(a_ae),   32'd1);
      check("rst_af",   32'(a_af),   32'd0);
      check("rst_cnt",  32'(a_cnt),  32'd0);
      check("rst_wm",   32'(a_wm),   32'd0);
      check("rst_drop", 32'(a_drop), 32'd0);
      check("rst_c_ov", 32'(c_ov),   32'd0);

      // A: fill 0..15 with output_ready low
      for (int i = 0; i < 16; i++) begin
         a_iv = 1'b1; a_din = 4'(i); #1;
         check("fill_ir", 32'(a_ir), 32'd1);
         tick();
         check("fill_cnt", 32'(a_cnt), 32'(i + 1));
         check("fill_af",  32'(a_af),  32'((i + 1) >= 14));
      end
      check("full_ir",  32'(a_ir),   32'd0);
      check("full_wm",  32'(a_wm),   32'd16);
      check("full_ov",  32'(a_ov),   32'd1);
      check("full_head", 32'(a_dout), 32'd0);

      // A: refused writes, last one alongside a pop
      a_din = 4'hA;
      for (int r = 0; r < 3; r++) begin
         a_ordy = (r == 2); #1;
         check("ref_ir", 32'(a_ir), 32'd0);
         if (r == 2) check("ref_head", 32'(a_dout), 32'd0);
         tick();
         check("ref_drop", 32'(a_drop), 32'(r + 1));
      end
      check("ref_cnt", 32'(a_cnt), 32'd15);

      // A: drain remaining 1..15 in order
      a_iv = 1'b0; a_ordy = 1'b1; #1;
      for (int k = 1; k < 16; k++) begin
         check("drn_ov",   32'(a_ov),   32'd1);
         check("drn_data", 32'(a_dout), 32'(k));
         check("drn_cnt",  32'(a_cnt),  32'(16 - k));
         check("drn_ae",   32'(a_ae),   32'((16 - k) <= 2));
         tick();
      end
      check("empty_cnt",  32'(a_cnt),  32'd0);
      check("empty_ov",   32'(a_ov),   32'd0);
      check("empty_ae",   32'(a_ae),   32'd1);
      check("empty_wm",   32'(a_wm),   32'd16);
      check("empty_drop", 32'(a_drop), 32'd3);

      // A: flush with 7 entries held
      a_ordy = 1'b0;
      for (int i = 0; i < 7; i++) begin
         a_iv = 1'b1; a_din = 4'(i + 3);
         tick();
      end
      check("pre_fl_cnt", 32'(a_cnt), 32'd7);
      a_flush = 1'b1; a_din = 4'hF; #1;
      check("fl_ir", 32'(a_ir), 32'd0);
      check("fl_ov", 32'(a_ov), 32'd0);
      tick();
      a_flush = 1'b0; a_iv = 1'b0; #1;
      check("post_fl_cnt",  32'(a_cnt),  32'd0);
      check("post_fl_ov",   32'(a_ov),   32'd0);
      check("post_fl_wm",   32'(a_wm),   32'd0);
      check("post_fl_drop", 32'(a_drop), 32'd3);
      a_iv = 1'b1; a_din = 4'd5;
      tick();
      a_iv = 1'b0; #1;
      check("fl_push_ov",   32'(a_ov),   32'd1);
      check("fl_push_data", 32'(a_dout), 32'd5);
      check("fl_push_cnt",  32'(a_cnt),  32'd1);
      check("fl_push_wm",   32'(a_wm),   32'd1);

      // B: 20-word stream through depth 5 with patterned valid/ready
      sent = 0; recvd = 0;
      for (int cyc = 0; cyc < 300 && recvd < 20; cyc++) begin
         b_iv   = (sent < 20) && vpat[cyc % 32];
         b_din  = 8'(8'h30 + sent);
         b_ordy = rpat[(cyc + 7) % 32];
         #1;
         check("b_cnt", 32'(b_cnt), 32'(q.size()));
         check("b_ir",  32'(b_ir),  32'(q.size() < 5));
         check("b_ov",  32'(b_ov),  32'(q.size() != 0));
         if (b_ov && b_ordy && q.size() != 0) begin
            exp_b = q.pop_front();
            check("b_data", 32'(b_dout), 32'(exp_b));
            recvd++;
         end
         if (b_iv && b_ir) begin
            q.push_back(b_din);
            sent++;
         end
         tick();
      end
      b_iv = 1'b0; b_ordy = 1'b0; #1;
      check("b_recvd", 32'(recvd), 32'd20);
      check("b_end_cnt", 32'(b_cnt), 32'd0);

      // C: registered output, two-cycle latency
      c_iv = 1'b1; c_din = 4'hA;
      tick();
      c_iv = 1'b0; #1;
      check("c_lat1_ov",  32'(c_ov),  32'd0);
      check("c_lat1_cnt", 32'(c_cnt), 32'd1);
      tick();
      check("c_lat2_ov",   32'(c_ov),   32'd1);
      check("c_lat2_data", 32'(c_dout), 32'hA);
      for (int i = 0; i < 16; i++) begin
         c_iv = 1'b1; c_din = 4'(i); #1;
         check("c_fill_ir", 32'(c_ir), 32'd1);
         tick();
         check("c_hold_data", 32'(c_dout), 32'hA);
      end
      c_iv = 1'b0; #1;
      check("c_full_cnt", 32'(c_cnt), 32'd17);
      check("c_full_ir",  32'(c_ir),  32'd0);
      check("c_full_af",  32'(c_af),  32'd1);
      check("c_full_wm",  32'(c_wm),  32'd17);
      tick();
      check("c_stall_data", 32'(c_dout), 32'hA);
      check("c_stall_ov",   32'(c_ov),   32'd1);

      // C: asynchronous reset mid-stream
      reset = 1'b1; #1;
      check("c_arst_ov",  32'(c_ov),  32'd0);
      check("c_arst_cnt", 32'(c_cnt), 32'd0);
      check("c_arst_ir",  32'(c_ir),  32'd1);
      tick();
      reset = 1'b0;
      tick();
      check("c_post_rst_ov", 32'(c_ov), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
